// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int STG_WB    = 5;
    localparam int NSTG      = STG_WB + 1;

    // A stage stall freezes itself and every stage upstream of it.
    function automatic logic [NSTG-1:0] hold_upto(input int stg);
        logic [NSTG-1:0] m;
        m = '0;
        for (int i = STG_PC; i < NSTG; i++) m[i] = (i <= stg);
        return m;
    endfunction

    localparam logic [NSTG-1:0] STALL_NONE = '0;
    localparam logic [NSTG-1:0] STALL_ID   = hold_upto(STG_IDEX);
    localparam logic [NSTG-1:0] STALL_EX   = hold_upto(STG_EXMEM);
    localparam logic [NSTG-1:0] STALL_MEM  = hold_upto(STG_MEMWB);
    localparam logic [31:0]     ZERO32     = 32'h0;
    localparam int              IFID_BIT   = STG_IFID;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage requests in, per-stage hold / redirect status out.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic            stallreq_id;
    logic            stallreq_ex;
    logic            stallreq_mem;
    logic            excp_req;
    logic [31:0]     excp_pc;
    logic [NSTG-1:0] stall;
    logic            flush;
    logic [31:0]     new_pc;
    logic [7:0]      stall_cnt;
    logic            stall_timeout;
    logic            pending;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
        input  stall, flush, new_pc, stall_cnt, stall_timeout, pending
    );
    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
        output stall, flush, new_pc, stall_cnt, stall_timeout, pending
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: prioritised stall generation, exception flush/redirect and
// consecutive-stall watchdog for a 6-stage pipeline.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [7:0] STALL_LIMIT = 8'd200
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [31:0]     pc_q, pc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [NSTG-1:0] stall_req, stall_d;

    always_comb begin
        stall_req = bus.stallreq_mem ? STALL_MEM :
                    bus.stallreq_ex  ? STALL_EX  :
                    bus.stallreq_id  ? STALL_ID  : STALL_NONE;
        stall_d   = (!rst || state_q == FLUSH) ? STALL_NONE : stall_req;
        pc_d      = bus.excp_req ? bus.excp_pc : pc_q;
        pending_d = (state_q == FLUSH) && bus.excp_req;
        state_d   = bus.excp_req ? FLUSH :
                    (state_q == FLUSH) ? RUN :
                    (stall_req != STALL_NONE) ? STALL : RUN;
        // Entering FLUSH restarts the count even if a stall was active.
        cnt_d     = (state_d == FLUSH || stall_d == STALL_NONE) ? 8'd0 :
                    (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        timeout_d = timeout_q || (cnt_d != 8'd0 && cnt_d == STALL_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
            pc_q      <= ZERO32;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.stall         = stall_d;
    assign bus.flush         = (state_q == FLUSH);
    assign bus.new_pc        = (state_q == FLUSH) ? pc_q : ZERO32;
    assign bus.stall_cnt     = cnt_q;
    assign bus.stall_timeout = timeout_q;
    assign bus.pending       = pending_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall priority, flush/redirect, watchdog and reset abort.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    pipe_ctrl_if bus();
    pipe_ctrl #(.STALL_LIMIT(8'd200)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic all_idle(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_flush"}, 32'(bus.flush), 32'h0);
        chk({tag, "_newpc"}, bus.new_pc, 32'h0);
        chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'h0);
        chk({tag, "_pend"}, 32'(bus.pending), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        bus.stallreq_mem = 1'b1;
        bus.excp_req = 1'b0;
        bus.excp_pc = 32'h0;
        nxt(); nxt();
        all_idle("rst");
        chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
        bus.stallreq_mem = 1'b0;
        rst = 1'b1;
        nxt();
        // mem + id together: mem wins, count starts next cycle
        bus.stallreq_mem = 1'b1; bus.stallreq_id = 1'b1; #1;
        chk("memid_stall", 32'(bus.stall), 32'h1F);
        chk("memid_cnt0", 32'(bus.stall_cnt), 32'h0);
        nxt();
        chk("memid_cnt1", 32'(bus.stall_cnt), 32'h1);
        bus.stallreq_mem = 1'b0; bus.stallreq_id = 1'b0; #1;
        chk("none_stall", 32'(bus.stall), 32'h0);
        nxt();
        chk("release_cnt", 32'(bus.stall_cnt), 32'h0);
        bus.stallreq_ex = 1'b1; bus.stallreq_id = 1'b1; #1;
        chk("exid_stall", 32'(bus.stall), 32'h0F);
        nxt();
        bus.stallreq_ex = 1'b0; #1;
        chk("id_stall", 32'(bus.stall), 32'h07);
        chk("id_cnt1", 32'(bus.stall_cnt), 32'h1);
        nxt();
        chk("id_cnt2", 32'(bus.stall_cnt), 32'h2);
        bus.stallreq_id = 1'b0;
        nxt();
        chk("idle_cnt", 32'(bus.stall_cnt), 32'h0);
        // exception during an EX stall
        bus.stallreq_ex = 1'b1; bus.excp_req = 1'b1; bus.excp_pc = 32'h100;
        nxt();
        bus.excp_req = 1'b0; #1;
        chk("x1_flush", 32'(bus.flush), 32'h1);
        chk("x1_newpc", bus.new_pc, 32'h100);
        chk("x1_stall", 32'(bus.stall), 32'h0);
        chk("x1_cnt", 32'(bus.stall_cnt), 32'h0);
        nxt(); #1;
        chk("x1_after_flush", 32'(bus.flush), 32'h0);
        chk("x1_after_newpc", bus.new_pc, 32'h0);
        chk("x1_after_stall", 32'(bus.stall), 32'h0F);
        bus.stallreq_ex = 1'b0;
        nxt();
        // back-to-back exceptions
        bus.excp_req = 1'b1; bus.excp_pc = 32'h200;
        nxt();
        bus.excp_pc = 32'h300; #1;
        chk("b2b_flush1", 32'(bus.flush), 32'h1);
        chk("b2b_newpc1", bus.new_pc, 32'h200);
        nxt();
        bus.excp_req = 1'b0; #1;
        chk("b2b_flush2", 32'(bus.flush), 32'h1);
        chk("b2b_newpc2", bus.new_pc, 32'h300);
        chk("b2b_pend", 32'(bus.pending), 32'h1);
        nxt();
        all_idle("b2b_end");
        // watchdog
        bus.stallreq_ex = 1'b1;
        repeat (199) nxt();
        chk("wd_cnt199", 32'(bus.stall_cnt), 32'd199);
        chk("wd_to199", 32'(bus.stall_timeout), 32'h0);
        nxt();
        chk("wd_cnt200", 32'(bus.stall_cnt), 32'd200);
        chk("wd_to200", 32'(bus.stall_timeout), 32'h1);
        repeat (55) nxt();
        chk("wd_cnt255", 32'(bus.stall_cnt), 32'hFF);
        nxt();
        chk("wd_sat", 32'(bus.stall_cnt), 32'hFF);
        bus.stallreq_ex = 1'b0;
        nxt();
        chk("wd_rel_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("wd_rel_to", 32'(bus.stall_timeout), 32'h1);
        bus.excp_req = 1'b1; bus.excp_pc = 32'h4;
        nxt();
        bus.excp_req = 1'b0; #1;
        chk("wd_flush_to", 32'(bus.stall_timeout), 32'h1);
        nxt();
        chk("wd_post_to", 32'(bus.stall_timeout), 32'h1);
        // reset right after an exception aborts the flush
        bus.excp_req = 1'b1; bus.excp_pc = 32'h400;
        nxt();
        bus.excp_req = 1'b0; rst = 1'b0;
        nxt();
        rst = 1'b1; #1;
        all_idle("abort");
        chk("abort_timeout", 32'(bus.stall_timeout), 32'h0);
        nxt();
        chk("abort_flush2", 32'(bus.flush), 32'h0);
        // reset discards a pending back-to-back redirect
        bus.excp_req = 1'b1; bus.excp_pc = 32'h500;
        nxt();
        bus.excp_pc = 32'h600;
        nxt();
        bus.excp_req = 1'b0; rst = 1'b0;
        nxt();
        rst = 1'b1; #1;
        all_idle("pabort");
        nxt();
        chk("pabort_flush2", 32'(bus.flush), 32'h0);
        chk("pabort_newpc2", bus.new_pc, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 8'd200: consecutive-stall-cycle count that raises stall_timeout.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when rst==0).
REQ-004 SHALL have port stallreq_id  input  1  ID stage requests a stall (load-use hazard).
REQ-005 SHALL have port stallreq_ex  input  1  EX stage requests a stall (multi-cycle mult/div/madd).
REQ-006 SHALL have port stallreq_mem  input  1  MEM stage requests a stall (data memory not ready).
REQ-007 SHALL have port excp_req  input  1  exception/redirect request, single-cycle pulse.
REQ-008 SHALL have port excp_pc  input  32  redirect target, valid with excp_req.
REQ-009 SHALL have port stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-010 SHALL have port flush  output  1  clear all pipeline registers to bubbles this cycle.
REQ-011 SHALL have port new_pc  output  32  PC to load while flush=1.
REQ-012 SHALL have port stall_cnt  output  8  current consecutive-stall count.
REQ-013 SHALL have port stall_timeout  output  1  sticky: a stall has lasted STALL_LIMIT cycles.

Function
REQ-014 SHALL implement FSM states RUN, STALL, FLUSH; FSM state, pending flag, pending PC, counter and timeout flag are registers.
REQ-015 SHALL drive stall combinationally, same cycle as the request, priority mem > ex > id: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-016 SHALL force stall=6'b000000 whenever state is FLUSH.
REQ-017 SHALL, in RUN or STALL, on excp_req=1: latch excp_pc and enter FLUSH next cycle; excp_req outranks every stall request.
REQ-018 SHALL hold flush=1 and new_pc=latched PC for exactly the one cycle spent in FLUSH; flush=0 and new_pc=32'h0 otherwise.
REQ-019 SHALL, on excp_req during FLUSH: set pending flag, latch the new excp_pc, and remain in FLUSH one more cycle with new_pc = the newer PC (back-to-back flush); otherwise FLUSH -> RUN.
REQ-020 SHALL ignore stall requests during FLUSH; stall requests seen on the cycle after FLUSH are honoured normally.
REQ-021 SHALL transition RUN -> STALL when any stall request is high and excp_req=0, and STALL -> RUN on the first cycle with no request.
REQ-022 SHALL increment stall_cnt every cycle stall!=0, saturating at 8'hFF, and clear it to 0 on the first cycle with stall=0 or on FLUSH entry.
REQ-023 SHALL set stall_timeout when stall_cnt reaches STALL_LIMIT; it stays set until reset, and flush does not clear it.
REQ-024 SHALL not alter stall behaviour on timeout; it only reports it.

Reset
REQ-025 SHALL, while rst==0 at posedge clk: state<=RUN, pending<=0, latched PC<=32'h0, stall_cnt<=0, stall_timeout<=0; outputs then read stall=0, flush=0, new_pc=0.
REQ-026 SHALL treat reset mid-FLUSH as an abort: no flush pulse follows reset release, and a pending redirect is discarded.
REQ-027 SHALL gate the combinational stall output to 0 while rst==0.

Structure
REQ-028 SHALL place the stall encodings, FSM state encodings, stage-bit indices and the 32-bit zero word in the shared defines file.
REQ-029 SHALL be a single module with no sub-modules; the stall counter stays inline.

Verification
REQ-030 SHALL cover: stallreq_mem=1 and stallreq_id=1 in the same cycle -> stall=6'b011111 that cycle, stall_cnt=1 the next cycle.
REQ-031 SHALL cover: excp_req=1 with excp_pc=32'h0000_0100 while stallreq_ex=1 -> next cycle flush=1, new_pc=32'h100, stall=0; the cycle after, flush=0.
REQ-032 SHALL cover: excp_req in consecutive cycles with PCs 32'h200 then 32'h300 -> two flush cycles, new_pc 32'h200 then 32'h300.
REQ-033 SHALL cover: stallreq_ex held 200 cycles with STALL_LIMIT=200 -> stall_timeout=1 once stall_cnt=200; after release it stays 1 and stall_cnt=0.
REQ-034 SHALL cover: rst=0 in the cycle after excp_req -> no flush pulse after rst returns to 1; all outputs 0.
